// File: rtl/fft_sched.sv
// fft_sched: FFT frame scheduler sharing one sample RAM between bridge and engine; define FFT_SCHED_ERR_EN for a sticky access-violation flag
module fft_sched (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_DATA_LOADED,
    input  logic [11:0] i_SAMPLES_NUMBER,
    input  logic        i_BR_WRITE,
    input  logic        i_BR_READ,
    input  logic [11:0] i_BR_INDEX,
    input  logic [15:0] i_BR_SAMPLE,
    input  logic        i_ENG_WRITE,
    input  logic        i_ENG_READ,
    input  logic [11:0] i_ENG_INDEX,
    input  logic [15:0] i_ENG_SAMPLE,
    input  logic        i_STAGE_DONE,
    input  logic        i_UNLOAD_DONE,
    output logic [11:0] o_RAM_ADDR,
    output logic [15:0] o_RAM_WDATA,
    output logic        o_RAM_WE,
    output logic        o_RAM_RE,
    output logic        o_STAGE_START,
    output logic [3:0]  o_STAGE_NUM,
    output logic        o_CALC_END,
    output logic        o_BUSY,
    output logic        o_ERR
);
    typedef enum logic [1:0] {S_LOAD, S_START, S_CALC, S_UNLOAD} state_t;
    state_t     state, state_n;
    logic [3:0] stage, stage_n, stages, stages_n;
    logic       br_own, eng_own;

    function automatic logic [3:0] floor_log2(input logic [11:0] n);
        floor_log2 = 4'd0;
        for (int i = 1; i < 12; i++)
            if (n[i]) floor_log2 = 4'(i);
    endfunction

    assign br_own  = state == S_LOAD || state == S_UNLOAD;
    assign eng_own = state == S_CALC;

    // next state: frame load, one start cycle per stage, stage run, result read-out
    always_comb begin
        state_n  = state;
        stage_n  = stage;
        stages_n = stages;
        case (state)
            S_LOAD: if (i_DATA_LOADED) begin
                stages_n = floor_log2(i_SAMPLES_NUMBER);
                stage_n  = 4'd0;
                state_n  = stages_n != 4'd0 ? S_START : S_UNLOAD;
            end
            S_START: state_n = S_CALC;
            S_CALC: if (i_STAGE_DONE) begin
                state_n = stage == stages - 4'd1 ? S_UNLOAD : S_START;
                stage_n = stage == stages - 4'd1 ? stage : stage + 4'd1;
            end
            S_UNLOAD: if (i_UNLOAD_DONE) state_n = S_LOAD;
            default: state_n = S_LOAD;
        endcase
    end

    // state and status outputs registered from the next state so they track the current state exactly
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_LOAD;
            stage         <= 4'd0;
            stages        <= 4'd0;
            o_STAGE_START <= 1'b0;
            o_STAGE_NUM   <= 4'd0;
            o_CALC_END    <= 1'b0;
            o_BUSY        <= 1'b0;
        end else begin
            state         <= state_n;
            stage         <= stage_n;
            stages        <= stages_n;
            o_STAGE_START <= state_n == S_START;
            o_STAGE_NUM   <= stage_n;
            o_CALC_END    <= state_n == S_UNLOAD;
            o_BUSY        <= state_n == S_START || state_n == S_CALC;
        end
    end

    // zero-latency RAM mux; the start cycle has no owner so both strobes stay low
    always_comb begin
        o_RAM_ADDR  = eng_own ? i_ENG_INDEX : i_BR_INDEX;
        o_RAM_WDATA = eng_own ? i_ENG_SAMPLE : i_BR_SAMPLE;
        o_RAM_WE    = !i_rst && (br_own ? i_BR_WRITE : eng_own && i_ENG_WRITE);
        o_RAM_RE    = !i_rst && (br_own ? i_BR_READ : eng_own && i_ENG_READ);
    end

`ifdef FFT_SCHED_ERR_EN
    logic viol;
    assign viol = (!br_own && (i_BR_WRITE || i_BR_READ)) || (!eng_own && (i_ENG_WRITE || i_ENG_READ));

    // sticky violation flag, cleared when a finished frame hands the RAM back for loading
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_ERR <= 1'b0;
        else if (state == S_UNLOAD && i_UNLOAD_DONE)
            o_ERR <= 1'b0;
        else if (viol)
            o_ERR <= 1'b1;
    end
`else
    assign o_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: directed and randomized checks of fft_sched against a behavioural frame model
module tb_fft_sched;
`ifdef FFT_SCHED_ERR_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif
    localparam int P_LOAD = 0, P_START = 1, P_CALC = 2, P_UNLOAD = 3;

    logic        clk = 0, rst = 1, dl = 0, br_wr = 0, br_rd = 0, eng_wr = 0, eng_rd = 0, sd = 0, ud = 0;
    logic [11:0] n = 0, br_idx = 0, eng_idx = 0, ram_addr;
    logic [15:0] br_smp = 0, eng_smp = 0, ram_wdata;
    logic        ram_we, ram_re, st_start, calc_end, busy, err;
    logic [3:0]  st_num;

    int total = 0, bad = 0;
    int m_ph = P_LOAD, m_stage = 0, m_stages = 0, m_err = 0;
    int nums[12];
    int cnt;
    bit seen;

    fft_sched dut (
        .i_clk(clk), .i_rst(rst), .i_DATA_LOADED(dl), .i_SAMPLES_NUMBER(n),
        .i_BR_WRITE(br_wr), .i_BR_READ(br_rd), .i_BR_INDEX(br_idx), .i_BR_SAMPLE(br_smp),
        .i_ENG_WRITE(eng_wr), .i_ENG_READ(eng_rd), .i_ENG_INDEX(eng_idx), .i_ENG_SAMPLE(eng_smp),
        .i_STAGE_DONE(sd), .i_UNLOAD_DONE(ud),
        .o_RAM_ADDR(ram_addr), .o_RAM_WDATA(ram_wdata), .o_RAM_WE(ram_we), .o_RAM_RE(ram_re),
        .o_STAGE_START(st_start), .o_STAGE_NUM(st_num), .o_CALC_END(calc_end), .o_BUSY(busy), .o_ERR(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lg(input int v);
        return v < 2 ? 0 : $clog2(v + 1) - 1;
    endfunction

    // frame model: stage count is floor(log2 N), each stage is a start cycle then a run until done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_LOAD; m_stage <= 0; m_stages <= 0; m_err <= 0;
        end else begin
            case (m_ph)
                P_LOAD: if (dl) begin
                    m_stages <= lg(int'(n)); m_stage <= 0;
                    m_ph <= lg(int'(n)) > 0 ? P_START : P_UNLOAD;
                end
                P_START: m_ph <= P_CALC;
                P_CALC: if (sd) begin
                    if (m_stage + 1 == m_stages) m_ph <= P_UNLOAD;
                    else begin m_stage <= m_stage + 1; m_ph <= P_START; end
                end
                default: if (ud) m_ph <= P_LOAD;
            endcase
            if (m_ph == P_UNLOAD && ud) m_err <= 0;
            else if (((br_wr || br_rd) && (m_ph == P_START || m_ph == P_CALC)) || ((eng_wr || eng_rd) && m_ph != P_CALC)) m_err <= 1;
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        chk("stage_start", st_start, m_ph == P_START);
        chk("stage_num", st_num, m_stage);
        chk("calc_end", calc_end, m_ph == P_UNLOAD);
        chk("busy", busy, m_ph == P_START || m_ph == P_CALC);
        chk("err", err, ERR_ON ? m_err : 0);
        if (rst || m_ph == P_LOAD || m_ph == P_UNLOAD) begin
            chk("addr_br", ram_addr, br_idx);
            chk("wdata_br", ram_wdata, br_smp);
            chk("we_br", ram_we, rst ? 0 : br_wr);
            chk("re_br", ram_re, rst ? 0 : br_rd);
        end else if (m_ph == P_CALC) begin
            chk("addr_eng", ram_addr, eng_idx);
            chk("wdata_eng", ram_wdata, eng_smp);
            chk("we_eng", ram_we, eng_wr);
            chk("re_eng", ram_re, eng_rd);
        end else begin
            chk("we_start", ram_we, 0);
            chk("re_start", ram_re, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic unload();
        ud = 1; tick(); ud = 0;
        @(negedge clk);
        chk("unload_clear", calc_end, 0);
    endtask

    task automatic run_frame(input int nv, input bit early, input bit probe, output int c_out);
        bit done = 0;
        c_out = 0;
        dl = 1; n = 12'(nv); tick(); dl = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (calc_end) done = 1;
            else if (st_start) begin
                if (c_out < 12) nums[c_out] = int'(st_num);
                c_out++;
                if (early) sd = 1;
                tick(); sd = 0;
                if (probe && c_out == 2) begin
                    br_wr = 1; br_idx = 12'h005; eng_wr = 1; eng_idx = 12'h0A0; eng_smp = 16'h1234;
                    @(negedge clk);
                    chk("lit_mux_addr", ram_addr, 'h0A0);
                    chk("lit_mux_wdata", ram_wdata, 'h1234);
                    chk("lit_mux_we", ram_we, 1);
                    tick(); br_wr = 0; eng_wr = 0;
                    @(negedge clk);
                    chk("lit_err", err, ERR_ON);
                end else tick();
                sd = 1; tick(); sd = 0;
            end else tick();
        end
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        br_wr = 1;
        @(negedge clk);
        @(negedge clk);
        chk("lit_rst_we", ram_we, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_num", st_num, 0);
        chk("lit_rst_calc_end", calc_end, 0);
        chk("lit_rst_err", err, 0);
        br_wr = 0; tick(); rst = 0; tick();

        run_frame(8, 1, 1, cnt);
        chk("lit_n8_starts", cnt, 3);
        chk("lit_n8_num0", nums[0], 0);
        chk("lit_n8_num1", nums[1], 1);
        chk("lit_n8_num2", nums[2], 2);
        chk("lit_n8_calc_end", calc_end, 1);
        chk("lit_n8_busy", busy, 0);
        unload();

        dl = 1; n = 12'd1; tick(); dl = 0;
        @(negedge clk);
        chk("lit_n1_calc_end", calc_end, 1);
        chk("lit_n1_start", st_start, 0);
        unload();

        run_frame(12, 0, 0, cnt); chk("lit_n12_starts", cnt, 3); unload();
        run_frame(0, 0, 0, cnt); chk("lit_n0_starts", cnt, 0); unload();
        run_frame(4095, 0, 0, cnt); chk("lit_n4095_starts", cnt, 11); chk("lit_n4095_last", nums[10], 10); unload();

        seen = 0;
        dl = 1; n = 12'd64; tick(); dl = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (st_start && st_num == 4'd2) seen = 1;
            else if (st_start) begin tick(); tick(); sd = 1; tick(); sd = 0; end
            else tick();
        end
        chk("lit_reach_stage2", seen, 1);
        #1 rst = 1; #2;
        chk("lit_mid_rst_num", st_num, 0);
        chk("lit_mid_rst_busy", busy, 0);
        chk("lit_mid_rst_calc_end", calc_end, 0);
        tick(); rst = 0; tick();
        run_frame(64, 0, 0, cnt); chk("lit_n64_starts", cnt, 6); unload();

        for (int c = 0; c < 4000; c++) begin
            tick();
            rst = $urandom_range(0, 399) == 0;
            dl = $urandom_range(0, 7) == 0;
            n = $urandom_range(0, 3) == 0 ? 12'($urandom_range(0, 3)) : 12'($urandom);
            sd = $urandom_range(0, 2) == 0;
            ud = $urandom_range(0, 5) == 0;
            br_wr = 1'($urandom); br_rd = 1'($urandom); eng_wr = 1'($urandom); eng_rd = 1'($urandom);
            br_idx = 12'($urandom); eng_idx = 12'($urandom);
            br_smp = 16'($urandom); eng_smp = 16'($urandom);
        end
        rst = 0; dl = 0; sd = 0; ud = 0; br_wr = 0; br_rd = 0; eng_wr = 0; eng_rd = 0;
        tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 SHALL have no HDL parameters; all widths fixed: index 12 bits, sample 16 bits, stage 4 bits.
REQ-002 i_clk  in  1  sole clock, rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_DATA_LOADED  in  1  bridge pulse: input frame fully written to RAM.
REQ-005 i_SAMPLES_NUMBER  in  12  frame length N, sampled with i_DATA_LOADED.
REQ-006 i_BR_WRITE, i_BR_READ  in  1 each  bridge RAM write/read request.
REQ-007 i_BR_INDEX / i_BR_SAMPLE  in  12 / 16  bridge RAM address / write data.
REQ-008 i_ENG_WRITE, i_ENG_READ  in  1 each  engine RAM write/read request.
REQ-009 i_ENG_INDEX / i_ENG_SAMPLE  in  12 / 16  engine RAM address / write data.
REQ-010 i_STAGE_DONE  in  1  engine pulse: current butterfly stage finished.
REQ-011 i_UNLOAD_DONE  in  1  bridge pulse: result read-out finished.
REQ-012 o_RAM_ADDR / o_RAM_WDATA  out  12 / 16  muxed RAM address / write data.
REQ-013 o_RAM_WE, o_RAM_RE  out  1 each  muxed RAM write/read strobe.
REQ-014 o_STAGE_START  out  1  one-cycle pulse starting a stage.
REQ-015 o_STAGE_NUM  out  4  current stage index, registered.
REQ-016 o_CALC_END  out  1  level: results valid, bridge owns RAM for read-out.
REQ-017 o_BUSY  out  1  high in S_START and S_CALC.
REQ-018 o_ERR  out  1  sticky access-violation flag (see Configuration).

Function
REQ-019 FSM states SHALL be S_LOAD, S_START, S_CALC, S_UNLOAD; all outputs except the RAM mux SHALL be registered.
REQ-020 S_LOAD: bridge owns RAM; on i_DATA_LOADED latch N, compute STAGES = bit position of MSB of N (floor log2), clear stage counter; go S_START if STAGES>0, else S_UNLOAD.
REQ-021 S_START: one cycle; o_STAGE_START=1, o_STAGE_NUM=stage counter; unconditionally go S_CALC; i_STAGE_DONE here ignored.
REQ-022 S_CALC: engine owns RAM; on i_STAGE_DONE, if stage==STAGES-1 go S_UNLOAD, else stage+1 and go S_START.
REQ-023 S_UNLOAD: bridge owns RAM, o_CALC_END=1; on i_UNLOAD_DONE go S_LOAD, o_CALC_END falls next cycle.
REQ-024 RAM mux SHALL be combinational, zero latency: owner's index/sample/write/read forwarded; o_RAM_WE/o_RAM_RE=0 in S_START; non-owner requests SHALL never reach RAM.
REQ-025 Owner request in the same cycle as a state-changing pulse SHALL still be forwarded (ownership switches on the next edge).
REQ-026 Non-power-of-two N SHALL be accepted; STAGES uses floor log2 (N=12 gives 3); N=0 or N=1 gives STAGES=0.
REQ-027 Maximum STAGES is 11 (N>=2048); stage counter SHALL never wrap.
REQ-028 i_DATA_LOADED outside S_LOAD and i_UNLOAD_DONE outside S_UNLOAD SHALL be ignored.

Reset
REQ-029 i_rst high SHALL force S_LOAD, stage=0, STAGES=0, o_STAGE_START=0, o_STAGE_NUM=0, o_CALC_END=0, o_BUSY=0, o_ERR=0 immediately, including mid-stage.
REQ-030 During reset the RAM mux SHALL follow S_LOAD ownership, with o_RAM_WE=o_RAM_RE=0.

Configuration
REQ-031 Macro FFT_SCHED_ERR_EN defined: o_ERR set on any non-owner write/read request, sticky until reset or S_UNLOAD->S_LOAD transition.
REQ-032 Macro FFT_SCHED_ERR_EN undefined: o_ERR tied 0, no detection logic; all other behaviour identical.

Verification
REQ-033 N=8, DATA_LOADED, three STAGE_DONE pulses (each >=2 cycles after START) -> START pulses with STAGE_NUM 0,1,2, then o_CALC_END=1.
REQ-034 N=1, DATA_LOADED -> S_UNLOAD directly, no o_STAGE_START, o_CALC_END=1 next cycle; UNLOAD_DONE -> o_CALC_END=0.
REQ-035 In S_CALC, i_BR_WRITE=1 index 0x005 while engine writes 0x0A0 data 0x1234 -> o_RAM_ADDR=0x0A0, WDATA=0x1234, WE=1; o_ERR=1 with macro, 0 without.
REQ-036 Assert i_rst at stage 2 of N=64 -> next sample: S_LOAD, o_STAGE_NUM=0, o_BUSY=0, o_CALC_END=0; fresh frame runs 6 stages.
REQ-037 i_STAGE_DONE asserted in the S_START cycle -> ignored; stage advances only on a pulse in S_CALC.
